// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port frame-buffer RAM between the display scan-out (reads
// from the front bank) and a pixel writer (writes into the back bank), and
// handles double-buffer swaps at the start of vertical blanking.
//
// Ports
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   disp_req/disp_x/disp_y  one-cycle pixel fetch request with 640x480 coords
//   disp_pixel/disp_valid   fetched pixel and its one-cycle strobe
//   wr_valid/wr_ready       writer handshake (wr_ready is combinational)
//   wr_addr/wr_data         linear back-buffer address and pixel data
//   wr_drop                 pulse when an accepted write is out of range
//   swap_req/frame_start    swap request and vblank pulse
//   front_buf/swap_done     displayed bank and swap-taken-effect pulse
//   disp_overrun            sticky: a display request was overwritten
//   mem_*                   single-port RAM interface, {bank, addr}
//
// State | meaning
// IDLE  | RAM unused this cycle
// RD    | display read issued to RAM (mem_en unless out of range)
// CAP   | RAM data returning; captured into disp_pixel at end of cycle
// WR    | back-buffer write issued (mem_en unless address out of range)
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int PIX_W = 12,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             disp_req,
    input  logic [9:0]       disp_x,
    input  logic [9:0]       disp_y,
    output logic [PIX_W-1:0] disp_pixel,
    output logic             disp_valid,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [14:0]      wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_drop,
    input  logic             swap_req,
    input  logic             frame_start,
    output logic             front_buf,
    output logic             swap_done,
    output logic             disp_overrun,
    output logic             mem_en,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [PIX_W-1:0] mem_wdata,
    input  logic [PIX_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    localparam logic [14:0] FB_LIMIT = 15'(FB_W * FB_H);
    localparam logic [9:0]  X_LIM    = 10'(FB_W * 4);
    localparam logic [9:0]  Y_LIM    = 10'(FB_H * 4);

    state_t      state;
    logic        pend;
    logic [9:0]  hold_x;
    logic [9:0]  hold_y;
    logic        rd_oor_q;
    logic        swap_pending;

    logic        xfer;
    logic [9:0]  rd_x;
    logic [9:0]  rd_y;
    logic [14:0] rd_yq;
    logic [14:0] rd_lin;
    logic        rd_oor;

    // Reads win: any live or held display request blocks the writer.
    assign wr_ready = !sys_rst && (state != RD) && !disp_req && !pend;
    assign xfer     = wr_valid && wr_ready;

    // A fresh request always supersedes the held one, so it is the one issued.
    always_comb begin
        rd_x   = disp_req ? disp_x : hold_x;
        rd_y   = disp_req ? disp_y : hold_y;
        rd_yq  = {7'd0, rd_y[9:2]};
        // row * 160 as (row << 7) + (row << 5); result truncated to 15 bits
        rd_lin = (rd_yq << 7) + (rd_yq << 5) + {7'd0, rd_x[9:2]};
        rd_oor = (rd_x >= X_LIM) || (rd_y >= Y_LIM);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            pend         <= 1'b0;
            hold_x       <= '0;
            hold_y       <= '0;
            rd_oor_q     <= 1'b0;
            swap_pending <= 1'b0;
            front_buf    <= 1'b0;
            disp_overrun <= 1'b0;
            disp_valid   <= 1'b0;
            disp_pixel   <= '0;
            wr_drop      <= 1'b0;
            swap_done    <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            disp_valid <= 1'b0;
            wr_drop    <= 1'b0;
            swap_done  <= 1'b0;

            if (disp_req && pend)
                disp_overrun <= 1'b1;

            // A swap_req coincident with frame_start counts as pending.
            if (frame_start && (swap_pending || swap_req)) begin
                front_buf    <= ~front_buf;
                swap_pending <= 1'b0;
                swap_done    <= 1'b1;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end

            case (state)
                RD: begin
                    state <= CAP;
                    if (disp_req) begin
                        pend   <= 1'b1;
                        hold_x <= disp_x;
                        hold_y <= disp_y;
                    end
                end
                default: begin
                    if (state == CAP) begin
                        disp_pixel <= rd_oor_q ? '0 : mem_rdata;
                        disp_valid <= 1'b1;
                    end
                    if (disp_req || pend) begin
                        state    <= RD;
                        pend     <= 1'b0;
                        rd_oor_q <= rd_oor;
                        mem_en   <= !rd_oor;
                        // bank latched here, so a later swap cannot redirect it
                        mem_addr <= {front_buf, rd_lin};
                    end else if (xfer) begin
                        state     <= WR;
                        mem_addr  <= {~front_buf, wr_addr};
                        mem_wdata <= wr_data;
                        if (wr_addr < FB_LIMIT) begin
                            mem_en <= 1'b1;
                            mem_we <= 1'b1;
                        end else begin
                            wr_drop <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter PIX_W, default 12, meaning pixel data width in bits.
REQ-002 SHALL have parameter FB_W, default 160, meaning frame-buffer width in pixels (display 640x480 downscaled by 4).
REQ-003 SHALL have parameter FB_H, default 120, meaning frame-buffer height in pixels.
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
  sys_clk  in  1  single clock, all logic on rising edge
  sys_rst  in  1  synchronous, active-high reset
  disp_req  in  1  one-cycle pixel fetch request, issued once per pixel tick
  disp_x  in  10  display column 0..639, sampled with disp_req
  disp_y  in  10  display row 0..479, sampled with disp_req
  disp_pixel  out  PIX_W  fetched pixel data
  disp_valid  out  1  one-cycle strobe marking disp_pixel valid
  wr_valid  in  1  writer has a write pending
  wr_ready  out  1  arbiter accepts the write this cycle
  wr_addr  in  15  linear back-buffer address, y*FB_W+x
  wr_data  in  PIX_W  write data
  wr_drop  out  1  one-cycle pulse when an accepted write is discarded
  swap_req  in  1  one-cycle request to swap the front and back buffers
  frame_start  in  1  one-cycle pulse at start of vertical blanking
  front_buf  out  1  bank currently being displayed
  swap_done  out  1  one-cycle pulse when a swap takes effect
  disp_overrun  out  1  sticky flag: a display request was lost
  mem_en  out  1  single-port RAM enable
  mem_we  out  1  RAM write enable
  mem_addr  out  16  {bank, 15-bit linear address}
  mem_wdata  out  PIX_W  RAM write data
  mem_rdata  in  PIX_W  RAM read data, valid one cycle after a read is issued

Function
REQ-005 SHALL implement a state machine with states IDLE, RD, CAP and WR, and SHALL drive all mem_* outputs, disp_pixel and disp_valid from registers.
REQ-006 SHALL define wr_ready = (state != RD) && !disp_req && !pend; this is the only combinational output. A transfer occurs when wr_valid && wr_ready are both high at a clock edge.
REQ-007 SHALL transition from any state except RD, on disp_req or pend, to RD; display requests always take priority over writes.
REQ-008 SHALL transition from IDLE, CAP or WR, on a write transfer with no display request, to WR.
REQ-009 SHALL transition from IDLE, CAP or WR to IDLE when there is neither a display request nor a write transfer.
REQ-010 SHALL transition from RD to CAP unconditionally.
REQ-011 SHALL, on disp_req arriving while in RD, set pend and capture the coordinates into a holding register; the pending request is served from CAP.
REQ-012 SHALL, on disp_req arriving while pend is already set, set disp_overrun; the newest request overwrites the held one.
REQ-013 SHALL have, during RD: mem_en=1, mem_we=0, mem_addr={front_buf as sampled at issue, (disp_y>>2)*FB_W + (disp_x>>2)}, with the multiply built from shift-add (160=128+32) and 15-bit truncation.
REQ-014 SHALL, for an out-of-range request (disp_x>=640 or disp_y>=480), keep mem_en=0 in RD and return disp_pixel=0.
REQ-015 SHALL register mem_rdata into disp_pixel at the end of CAP and SHALL raise disp_valid for exactly one cycle.
REQ-016 SHALL meet display latency: a disp_req in cycle N produces disp_valid in cycle N+3, or N+4 if the request was pended.
REQ-017 SHALL have, during WR: mem_en=1, mem_we=1, mem_addr={~front_buf, wr_addr}, mem_wdata=wr_data as captured at transfer.
REQ-018 SHALL allow back-to-back writes, one per cycle, while no display request is present.
REQ-019 SHALL handle an accepted write with wr_addr >= FB_W*FB_H by issuing no memory access (mem_en=0) and pulsing wr_drop one cycle later.
REQ-020 SHALL have mem_en=0 and mem_we=0 in IDLE and CAP.
REQ-021 SHALL set swap_pending on swap_req; frame_start with swap_pending (or coincident swap_req) SHALL toggle front_buf, clear swap_pending and pulse swap_done in the next cycle.
REQ-022 SHALL ignore frame_start when no swap is pending and SHALL treat multiple swap_req before a frame_start as a single swap.
REQ-023 SHALL leave a read already in RD/CAP at a swap on the bank sampled at issue, and SHALL target the old back bank for a write transferred before the toggle edge.

Reset
REQ-024 SHALL, on sys_rst high at a clock edge, go to state IDLE and clear pend, swap_pending, front_buf, disp_overrun, disp_valid, disp_pixel, wr_drop, swap_done, mem_en, mem_we, mem_addr and mem_wdata to 0.
REQ-025 SHALL hold wr_ready at 0 while sys_rst is high; reset mid-operation SHALL abort any read or write in flight, with no disp_valid or write issued afterwards.

Verification
REQ-026 SHALL cover this scenario: disp_req with x=8, y=4 at cycle 10 -> cycle 11 mem_en=1, mem_we=0, mem_addr=0x00A2 (1*160+2) -> cycle 13 disp_valid=1, disp_pixel=mem_rdata.
REQ-027 SHALL cover this scenario: wr_valid held with addr 0x0005, data 0xABC, plus disp_req in the same cycle -> wr_ready=0, read issued first; write to {1,0x0005} appears no later than 3 cycles after the read.
REQ-028 SHALL cover this scenario: disp_req at cycles 20 and 21 -> second request pended, disp_valid at 23 and 25, disp_overrun stays 0; a third disp_req at 22 -> disp_overrun=1.
REQ-029 SHALL cover this scenario: swap_req at 5, frame_start at 50 -> front_buf flips to 1 at 51 with swap_done=1 at 51 only; subsequent writes use bank 0.
REQ-030 SHALL cover this scenario: disp_x=640 request -> mem_en stays 0, disp_valid at N+3 with disp_pixel=0; wr_addr=19200 -> no mem access, wr_drop pulse.
REQ-031 SHALL cover this scenario: sys_rst asserted in RD -> next cycle all outputs 0, no disp_valid produced.
